// File: rtl/ha_array_pkg.sv
// Shared types and constants for the 8x8 ha_array partial-product interface.
package ha_array_pkg;

    localparam int unsigned NUM_ROWS  = 4;
    localparam int unsigned T_W       = 9;
    localparam int unsigned B_W       = 7;
    localparam int unsigned B_OFFSET  = 2;
    localparam int unsigned ROW_SHIFT = 2;
    localparam int unsigned PROD_W    = 16;
    localparam int unsigned ACC_W     = 17;
    localparam int unsigned CNT_W     = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_e;

    typedef struct packed {
        logic [B_W-1:0] b;
        logic [T_W-1:0] t;
    } row_t;

endpackage

// File: rtl/ha_array_row_weight.sv
// Combinational weight of one ha_array row: (t + (b << B_OFFSET)) << (ROW_SHIFT * idx).
module ha_array_row_weight
    import ha_array_pkg::*;
(
    input  logic [$bits(row_t)-1:0] row_i,
    input  logic [CNT_W-1:0]        idx_i,
    output logic [ACC_W-1:0]        weighted_o
);

    row_t             row;
    logic [ACC_W-1:0] row_val;

    always_comb begin
        row        = row_t'(row_i);
        row_val    = ACC_W'(row.t) + (ACC_W'(row.b) << B_OFFSET);
        weighted_o = row_val << (ROW_SHIFT * 32'(idx_i));
    end

endmodule

// File: rtl/unsigned_mul_8x8_ha_array_reducer.sv
// Captures four ha_array row pairs and reduces them one row per cycle into a
// 16-bit product plus overflow flag, returned over a valid/ready stream.
module unsigned_mul_8x8_ha_array_reducer
    import ha_array_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [B_W-1:0]    ha_array_0_b,
    input  logic [T_W-1:0]    ha_array_0_t,
    input  logic [B_W-1:0]    ha_array_1_b,
    input  logic [T_W-1:0]    ha_array_1_t,
    input  logic [B_W-1:0]    ha_array_2_b,
    input  logic [T_W-1:0]    ha_array_2_t,
    input  logic [B_W-1:0]    ha_array_3_b,
    input  logic [T_W-1:0]    ha_array_3_t,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_product,
    output logic              out_ovf
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    row_t             rows_q [NUM_ROWS];
    row_t             rows_d [NUM_ROWS];
    row_t             in_rows [NUM_ROWS];
    logic [ACC_W-1:0] weighted;
    logic             capture;

    always_comb begin
        in_rows[0] = '{b: ha_array_0_b, t: ha_array_0_t};
        in_rows[1] = '{b: ha_array_1_b, t: ha_array_1_t};
        in_rows[2] = '{b: ha_array_2_b, t: ha_array_2_t};
        in_rows[3] = '{b: ha_array_3_b, t: ha_array_3_t};
    end

    ha_array_row_weight u_row_weight (
        .row_i      (rows_q[cnt_q]),
        .idx_i      (cnt_q),
        .weighted_o (weighted)
    );

    // rst_n gates in_ready so no capture is advertised while reset is held.
    assign in_ready    = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign capture     = in_valid && in_ready;
    assign out_valid   = (state_q == DONE);
    assign out_product = acc_q[PROD_W-1:0];
    assign out_ovf     = acc_q[ACC_W-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rows_d  = rows_q;
        unique case (state_q)
            IDLE: ;
            ACCUM: begin
                acc_d = acc_q + weighted;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NUM_ROWS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            rows_d  = in_rows;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            for (int unsigned i = 0; i < NUM_ROWS; i++) begin
                rows_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rows_q  <= rows_d;
        end
    end

endmodule
